motor_ramp_ctrl: RTL and testbench

Sequences the drive-motor PWM and H-bridge direction bits so that software commands never reverse the bridge under load.
- Accepts a {direction, target duty} command.
- Ramps duty toward the target in fixed steps on a slow tick.
- On a direction change: ramps to zero, coasts for a dead time, then switches direction and ramps up.
- Sits between the APB3 register decode and the motor PWM modulator / MOTOR pins.

---
 rtl/motor_ramp_pkg.sv | 29 ++
 rtl/ramp_tick_gen.sv | 22 ++
 rtl/motor_ramp_ctrl.sv | 132 +++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ramp_pkg.sv
// Shared H-bridge codes, FSM encoding and duty helpers for the motor ramp sequencer.
package motor_ramp_pkg;

  localparam logic [3:0] DIR_COAST = 4'b0000;
  localparam logic [3:0] DIR_FWD   = 4'b1010;
  localparam logic [3:0] DIR_REV   = 4'b0101;
  localparam logic [3:0] DIR_LEFT  = 4'b1001;
  localparam logic [3:0] DIR_RIGHT = 4'b0110;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RAMP = 3'd1,
    STOP = 3'd2,
    DEAD = 3'd3,
    HOLD = 3'd4
  } state_t;

  function automatic logic is_legal_dir(input logic [3:0] d);
    return d inside {DIR_COAST, DIR_FWD, DIR_REV, DIR_LEFT, DIR_RIGHT};
  endfunction

  // Moves cur toward tgt by at most step, never past it.
  function automatic logic [23:0] step_toward(input logic [23:0] cur, input logic [23:0] tgt,
                                              input logic [23:0] step);
    if (cur < tgt) return (tgt - cur > step) ? cur + step : tgt;
    else           return (cur - tgt > step) ? cur - step : tgt;
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running prescaler: tick is high for the one PCLK cycle in which the count wraps.
module ramp_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic PCLK,
  input  logic PRESET,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == W'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) cnt_q <= '0;
    else        cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Duty/direction sequencer that never reverses the H-bridge under load.
// Optional MOTOR_RAMP_IRQ_EN adds done_irq, pulsed when an accepted command completes.
module motor_ramp_ctrl
  import motor_ramp_pkg::*;
#(
  parameter int PERIOD         = 100000,
  parameter int STEP           = 1000,
  parameter int TICK_DIV       = 100000,
  parameter int DEADTIME_TICKS = 50
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_dir,
  input  logic [23:0] cmd_duty,
  input  logic        estop,
  output logic [23:0] duty_out,
  output logic [3:0]  motor_out,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state_o
`ifdef MOTOR_RAMP_IRQ_EN
  ,
  output logic        done_irq
`endif
);

  localparam logic [23:0] PERIOD_V  = 24'(PERIOD);
  localparam logic [23:0] STEP_V    = 24'(STEP);
  localparam logic [15:0] DEAD_LAST = 16'(DEADTIME_TICKS - 1);

  state_t      state_q, state_d;
  logic [23:0] duty_q, duty_d, tgt_q, tgt_d, stepped;
  logic [3:0]  motor_q, motor_d, dir_q, dir_d, acc_dir;
  logic [15:0] dead_q, dead_d;
  logic        err_d, err_q, tick, accept, acc_legal;

  ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.PCLK(PCLK), .PRESET(PRESET), .tick(tick));

  assign cmd_ready = ((state_q == IDLE) || (state_q == HOLD)) && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign acc_legal = is_legal_dir(cmd_dir);
  assign acc_dir   = acc_legal ? cmd_dir : DIR_COAST;
  assign busy      = (state_q == RAMP) || (state_q == STOP) || (state_q == DEAD);

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    motor_d = motor_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    err_d   = 1'b0;
    stepped = step_toward(duty_q, (state_q == STOP) ? 24'd0 : tgt_q, STEP_V);
    if (estop) begin
      state_d = IDLE;
      duty_d  = '0;
      motor_d = DIR_COAST;
    end else begin
      case (state_q)
        IDLE, HOLD: if (accept) begin
          tgt_d = (acc_dir == DIR_COAST) ? 24'd0 : ((cmd_duty > PERIOD_V) ? PERIOD_V : cmd_duty);
          dir_d = acc_dir;
          err_d = !acc_legal;
          if (acc_dir == motor_q) state_d = RAMP;
          else if (duty_q == '0 && motor_q == DIR_COAST) begin
            motor_d = acc_dir;
            state_d = RAMP;
          end else state_d = STOP;
        end
        RAMP: begin
          if (tick) duty_d = stepped;
          if (duty_q == tgt_q || (tick && stepped == tgt_q))
            state_d = (tgt_q == '0 && dir_q == DIR_COAST) ? IDLE : HOLD;
        end
        STOP: begin
          if (tick) duty_d = stepped;
          if (duty_q == '0 || (tick && stepped == '0)) begin
            motor_d = DIR_COAST;
            dead_d  = '0;
            state_d = (dir_q == DIR_COAST) ? IDLE : DEAD;
          end
        end
        DEAD: if (tick) begin
          if (dead_q == DEAD_LAST) begin
            motor_d = dir_q;
            state_d = RAMP;
          end else dead_d = dead_q + 16'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      duty_q  <= '0;
      motor_q <= DIR_COAST;
      tgt_q   <= '0;
      dir_q   <= DIR_COAST;
      dead_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      motor_q <= motor_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      err_q   <= err_d;
    end
  end

  assign duty_out  = duty_q;
  assign motor_out = motor_q;
  assign err       = err_q;
  assign state_o   = state_q;

`ifdef MOTOR_RAMP_IRQ_EN
  // Only busy states can complete a command; estop exits are excluded explicitly.
  logic done_q;
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) done_q <= 1'b0;
    else        done_q <= !estop && busy && (state_d == IDLE || state_d == HOLD);
  end
  assign done_irq = done_q;
`endif

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scoreboard bench for motor_ramp_ctrl: a command-level model queues the expected
// {motor, duty} change sequence with tick spacing; a monitor compares each DUT change.
module tb_motor_ramp_ctrl;

  localparam int PERIOD = 1000, STEP = 100, TICK_DIV = 10, DEADT = 3;
  localparam logic [3:0] C_COAST = 4'b0000, C_FWD = 4'b1010, C_REV = 4'b0101,
                         C_LEFT = 4'b1001, C_RIGHT = 4'b0110;

  typedef struct {
    logic [3:0]  motor;
    logic [23:0] duty;
    int          dt;     // ticks since previous change; -1 = not tick-driven
  } exp_t;

  logic        PCLK = 0, PRESET = 1, cmd_valid = 0, estop = 0;
  logic [3:0]  cmd_dir = 0;
  logic [23:0] cmd_duty = 0;
  logic        cmd_ready, busy, err;
  logic [23:0] duty_out;
  logic [3:0]  motor_out;
  logic [2:0]  state_o;
`ifdef MOTOR_RAMP_IRQ_EN
  logic        done_irq;
  int          irq_cnt = 0;
`endif

  int   total = 0, bad = 0;
  exp_t q[$];
  int   bcnt = 0, since = 0;
  bit   accept_now = 0, mon_en = 1;
  logic [27:0] prev = '0;
  logic [23:0] m_duty = 0;
  logic [3:0]  m_motor = 0;

  motor_ramp_ctrl #(.PERIOD(PERIOD), .STEP(STEP), .TICK_DIV(TICK_DIV), .DEADTIME_TICKS(DEADT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .estop(estop), .duty_out(duty_out),
    .motor_out(motor_out), .busy(busy), .err(err), .state_o(state_o)
`ifdef MOTOR_RAMP_IRQ_EN
    , .done_irq(done_irq)
`endif
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Independent tick reference: counts ticks since the last accept or observed change.
  always @(posedge PCLK) begin
    if (PRESET) bcnt = 0;
    else begin
      if (accept_now) begin since = 0; accept_now = 0; end
      else if (bcnt == TICK_DIV - 1) since++;
      bcnt = (bcnt == TICK_DIV - 1) ? 0 : bcnt + 1;
    end
  end

  always @(negedge PCLK) begin
    exp_t e;
    if (mon_en && !PRESET && {motor_out, duty_out} != prev) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_change: got motor=%b duty=%0d with nothing expected", motor_out, duty_out);
      end else begin
        e = q.pop_front();
        check("motor", 32'(motor_out), 32'(e.motor));
        check("duty", 32'(duty_out), 32'(e.duty));
        if (e.dt >= 0) check("tick_spacing", since, e.dt);
      end
      since = 0;
      prev  = {motor_out, duty_out};
    end
  end

`ifdef MOTOR_RAMP_IRQ_EN
  always @(negedge PCLK) if (done_irq) irq_cnt++;
`endif

  function automatic bit legal(input logic [3:0] d);
    return d inside {C_COAST, C_FWD, C_REV, C_LEFT, C_RIGHT};
  endfunction

  function automatic void push_ramp(input logic [23:0] from, input logic [23:0] to, input logic [3:0] m);
    int v = int'(from);
    while (v != int'(to)) begin
      if (v < int'(to)) v = (int'(to) - v > STEP) ? v + STEP : int'(to);
      else              v = (v - int'(to) > STEP) ? v - STEP : int'(to);
      q.push_back('{m, 24'(v), 1});
    end
  endfunction

  task automatic issue(input logic [3:0] dir, input logic [23:0] duty, input bit wait_done);
    int n = 0;
    bit ill;
    logic [3:0]  nd, m_imm;
    logic [23:0] t;
    logic [2:0]  fst;
    @(negedge PCLK); #1;
    while (!cmd_ready && n < 3000) begin @(negedge PCLK); #1; n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL ready_timeout: cmd_ready never rose for dir=%b", dir);
      return;
    end
    ill = !legal(dir);
    nd  = ill ? C_COAST : dir;
    t   = (nd == C_COAST) ? 24'd0 : ((duty > 24'(PERIOD)) ? 24'(PERIOD) : duty);
    fst = (t == 0 && nd == C_COAST) ? 3'd0 : 3'd4;
    m_imm = m_motor;
    if (nd == m_motor) push_ramp(m_duty, t, nd);
    else if (m_duty == 0 && m_motor == C_COAST) begin
      m_imm = nd;
      q.push_back('{nd, 24'd0, 0});
      push_ramp(0, t, nd);
    end else begin
      if (m_duty == 0) q.push_back('{C_COAST, 24'd0, -1});
      else begin
        push_ramp(m_duty, 0, m_motor);
        q[$].motor = C_COAST;
      end
      if (nd != C_COAST) begin
        q.push_back('{nd, 24'd0, DEADT});
        push_ramp(0, t, nd);
      end
    end
    cmd_dir = dir; cmd_duty = duty; cmd_valid = 1; accept_now = 1;
`ifdef MOTOR_RAMP_IRQ_EN
    irq_cnt = 0;
`endif
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 0;
    #1;
    check("err_acc1", 32'(err), 32'(ill));
    check("motor_acc1", 32'(motor_out), 32'(m_imm));
    check("busy_acc1", 32'(busy), 1);
    if (ill) begin @(negedge PCLK); #1; check("err_one_cycle", 32'(err), 0); end
    m_duty = t; m_motor = nd;
    if (!wait_done) return;
    n = 0;
    while (!(q.size() == 0 && (state_o == 3'd0 || state_o == 3'd4)) && n < 3000) begin
      @(negedge PCLK); #1; n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL done_timeout: state=%0d pending=%0d", state_o, q.size());
    end
    check("final_state", 32'(state_o), 32'(fst));
    check("final_duty", 32'(duty_out), 32'(t));
    check("final_motor", 32'(motor_out), 32'(nd));
    check("final_ready", 32'(cmd_ready), 1);
    check("final_busy", 32'(busy), 0);
`ifdef MOTOR_RAMP_IRQ_EN
    check("done_irq_count", irq_cnt, 1);
`endif
  endtask

  task automatic resync();
    q.delete();
    prev = '0; m_duty = 0; m_motor = C_COAST;
    mon_en = 1;
  endtask

  initial begin
    logic [3:0] dirs[5];
    logic [3:0] d;
    logic [23:0] du;
    int n;
    dirs = '{C_COAST, C_FWD, C_REV, C_LEFT, C_RIGHT};
    repeat (3) @(negedge PCLK);
    PRESET = 0;
    @(negedge PCLK); #1;
    check("rst_duty", 32'(duty_out), 0);
    check("rst_motor", 32'(motor_out), 0);
    check("rst_state", 32'(state_o), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ready", 32'(cmd_ready), 1);

    issue(C_FWD, 350, 1);
    issue(C_REV, 200, 1);
    issue(C_FWD, 5000, 1);
    issue(C_COAST, 0, 1);

    // estop while ramping at duty 200
    issue(C_FWD, 800, 0);
    n = 0;
    while (duty_out != 24'd200 && n < 500) begin @(negedge PCLK); #1; n++; end
    check("estop_reach_200", 32'(duty_out), 200);
    mon_en = 0;
    estop  = 1;
    @(negedge PCLK); #1;
    check("estop_duty", 32'(duty_out), 0);
    check("estop_motor", 32'(motor_out), 0);
    check("estop_state", 32'(state_o), 0);
    check("estop_ready", 32'(cmd_ready), 0);
    repeat (25) @(negedge PCLK);
    #1;
    check("estop_hold_ready", 32'(cmd_ready), 0);
    check("estop_hold_duty", 32'(duty_out), 0);
`ifdef MOTOR_RAMP_IRQ_EN
    check("estop_no_irq", irq_cnt, 0);
`endif
    estop = 0;
    #1;
    check("estop_release_ready", 32'(cmd_ready), 1);
    resync();

    issue(C_LEFT, 400, 1);
    issue(4'b1100, 300, 1);
    issue(C_RIGHT, 0, 1);
    issue(C_RIGHT, 0, 1);
    issue(C_FWD, 150, 1);

    for (int i = 0; i < 16; i++) begin
      d = dirs[$urandom_range(0, 4)];
      if ($urandom_range(0, 5) == 0) begin
        d = 4'($urandom_range(0, 15));
        while (legal(d)) d = 4'($urandom_range(0, 15));
      end
      du = 24'($urandom_range(0, 1300));
      if ($urandom_range(0, 5) == 0) du = 0;
      issue(d, du, 1);
    end

    // reset in the middle of a ramp
    issue(C_REV, 900, 0);
    repeat (40) @(negedge PCLK);
    mon_en = 0;
    PRESET = 1;
    #1;
    check("midrst_duty", 32'(duty_out), 0);
    check("midrst_motor", 32'(motor_out), 0);
    check("midrst_state", 32'(state_o), 0);
    check("midrst_busy", 32'(busy), 0);
    repeat (2) @(negedge PCLK);
    PRESET = 0;
    #1;
    check("midrst_ready", 32'(cmd_ready), 1);
    resync();
    issue(C_RIGHT, 250, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
